// File: rtl/display_mux7_if.sv
// Bundle of the load/operand inputs and display outputs of display_mux7.
// The master side drives the operands and load; the slave side is the display mux.
interface display_mux7_if;
    logic       load;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] res;
    logic       ready;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;

    modport master (
        output load, a, b, res,
        input  ready, seg, an, frame
    );

    modport slave (
        input  load, a, b, res,
        output ready, seg, an, frame
    );
endinterface

// File: rtl/display_mux7.sv
// Four-digit multiplexed 7-segment driver showing A, B, a dash and the result.
// A captured triple is held for HOLD complete scan frames before a new load is taken.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready=1, next load captures a/b/res
// S_HOLD | ready=0, counting frame pulses until HOLD frames completed
module display_mux7 #(
    parameter int DIV  = 50000,
    parameter int HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    display_mux7_if.slave  bus
);

    localparam int CW = $clog2(DIV);
    localparam int FW = $clog2(HOLD + 1);
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          state;
    logic            ready_q;
    logic [FW-1:0]   fcnt;
    logic [2:0]      ra;
    logic [2:0]      rb;
    logic [2:0]      rr;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [6:0]      seg_q;
    logic [3:0]      an_q;
    logic            tick;
    logic            frame_pulse;
    logic [6:0]      digit;

    function automatic logic [6:0] dec7(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    assign tick        = (cnt == CW'(DIV - 1));
    assign frame_pulse = tick && (idx == 2'd3);

    always_comb begin
        digit = DASH;
        case (idx)
            2'd3:    digit = dec7(ra);
            2'd2:    digit = dec7(rb);
            2'd1:    digit = DASH;
            default: digit = dec7(rr);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A frame pulse in the capture cycle is seen while still in S_IDLE, so it is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            fcnt    <= '0;
            ra      <= 3'd0;
            rb      <= 3'd0;
            rr      <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load && ready_q) begin
                        ra      <= bus.a;
                        rb      <= bus.b;
                        rr      <= bus.res;
                        fcnt    <= '0;
                        state   <= S_HOLD;
                        ready_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (frame_pulse) begin
                        if (fcnt == FW'(HOLD - 1)) begin
                            fcnt    <= '0;
                            state   <= S_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Blank everything for the first count of each slot so the digit switch never ghosts.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt == '0) begin
            an_q  <= 4'b1111;
            seg_q <= BLANK;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= digit;
        end
    end

    assign bus.ready = ready_q;
    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_pulse;

endmodule

// File: tb/tb_display_mux7.sv
// Bench for display_mux7 with DIV=4, HOLD=2: operand table with expected digit patterns
// queued at load time, plus hand sequences for reset, busy loads and reset mid-hold.
module tb_display_mux7;
    localparam int DIV  = 4;
    localparam int HOLD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    display_mux7_if bus();

    display_mux7 #(.DIV(DIV), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] res;
        bit         busy_load;
        logic [6:0] s3;
        logic [6:0] s2;
        logic [6:0] s0;
    } vec_t;

    typedef struct {
        logic [6:0] s3;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int an2idx(input logic [3:0] an);
        case (an)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic run_vector(input vec_t v);
        exp_t       e;
        exp_t       g;
        int         nfr;
        int         last;
        int         d;
        bit         done;
        bit         blank_ok;
        logic [6:0] got[4];
        for (int k = 0; k < 4; k++) got[k] = 7'bx;

        for (int k = 0; k < 100 && bus.ready !== 1'b1; k++) step();
        chk("ready_before_load", bus.ready, 1);

        bus.load = 1'b1;
        bus.a    = v.a;
        bus.b    = v.b;
        bus.res  = v.res;
        e.s3 = v.s3;
        e.s2 = v.s2;
        e.s1 = 7'b0111111;
        e.s0 = v.s0;
        exp_q.push_back(e);
        step();
        bus.load = 1'b0;
        chk("ready_low_after_capture", bus.ready, 0);

        nfr = 0; last = 0; done = 1'b0; blank_ok = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (bus.an == 4'b1111 && bus.seg !== 7'b1111111) blank_ok = 1'b0;
            if (bus.frame) begin
                nfr++;
                if (nfr == 2) begin
                    chk("ready_low_at_2nd_frame", bus.ready, 0);
                    chk("frame_spacing", i - last, 16);
                end
                last = i;
            end else if (nfr == 1) begin
                d = an2idx(bus.an);
                if (d >= 0) got[d] = bus.seg;
            end
            if (nfr == 2) begin
                step();
                chk("ready_high_after_hold", bus.ready, 1);
                done = 1'b1;
            end else begin
                if (v.busy_load && i == 3) begin
                    bus.load = 1'b1;
                    bus.a    = 3'd7;
                    bus.b    = 3'd1;
                    bus.res  = 3'd7;
                end else begin
                    bus.load = 1'b0;
                end
                step();
            end
        end
        bus.load = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hold_timeout: saw %0d frame pulses, required %0d", nfr, HOLD);
        end
        chk("blank_when_no_digit", blank_ok, 1);

        g = exp_q.pop_front();
        chk("digit3_seg", got[3], g.s3);
        chk("digit2_seg", got[2], g.s2);
        chk("digit1_seg", got[1], g.s1);
        chk("digit0_seg", got[0], g.s0);
    endtask

    initial begin
        vecs[0] = '{3'd5, 3'd3, 3'd5, 1'b1, 7'b0010010, 7'b0110000, 7'b0010010};
        vecs[1] = '{3'd2, 3'd2, 3'd0, 1'b0, 7'b0100100, 7'b0100100, 7'b1000000};
        vecs[2] = '{3'd7, 3'd1, 3'd7, 1'b0, 7'b1111000, 7'b1111001, 7'b1111000};
        vecs[3] = '{3'd4, 3'd6, 3'd6, 1'b0, 7'b0011001, 7'b0000010, 7'b0000010};
        vecs[4] = '{3'd0, 3'd0, 3'd0, 1'b0, 7'b1000000, 7'b1000000, 7'b1000000};
        vecs[5] = '{3'd3, 3'd1, 3'd3, 1'b0, 7'b0110000, 7'b1111001, 7'b0110000};

        // reset with a load held high: nothing may be captured
        rst_n    = 1'b0;
        bus.load = 1'b1;
        bus.a    = 3'd7;
        bus.b    = 3'd7;
        bus.res  = 3'd7;
        for (int k = 0; k < 3; k++) step();
        chk("reset_an", bus.an, 4'b1111);
        chk("reset_seg", bus.seg, 7'b1111111);
        chk("reset_ready", bus.ready, 1);
        chk("reset_frame", bus.frame, 0);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        step();
        chk("first_cycle_blank_an", bus.an, 4'b1111);
        step();
        chk("first_digit_an", bus.an, 4'b1110);
        chk("first_digit_seg", bus.seg, 7'b1000000);

        for (int v = 0; v < 6; v++) run_vector(vecs[v]);

        // reset one cycle after a capture
        for (int k = 0; k < 100 && bus.ready !== 1'b1; k++) step();
        bus.load = 1'b1;
        bus.a    = 3'd6;
        bus.b    = 3'd4;
        bus.res  = 3'd6;
        step();
        chk("midhold_ready_low", bus.ready, 0);
        rst_n   = 1'b0;
        bus.a   = 3'd3;
        bus.b   = 3'd3;
        bus.res = 3'd3;
        step();
        chk("midhold_reset_ready", bus.ready, 1);
        chk("midhold_reset_an", bus.an, 4'b1111);
        chk("midhold_reset_seg", bus.seg, 7'b1111111);
        rst_n    = 1'b1;
        bus.load = 1'b0;
        step();
        chk("midhold_blank_an", bus.an, 4'b1111);
        step();
        chk("midhold_digit0_an", bus.an, 4'b1110);
        chk("midhold_rr_cleared", bus.seg, 7'b1000000);
        for (int k = 0; k < 40 && bus.an !== 4'b0111; k++) step();
        chk("midhold_digit3_an", bus.an, 4'b0111);
        chk("midhold_ra_cleared", bus.seg, 7'b1000000);
        chk("midhold_still_ready", bus.ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
